// File: rtl/ppu_conv_pkg.sv
// Shared types and helpers for the PPU tile converter family.
// Holds the FSM state encoding, bpp mode encodings and per-depth helper functions.
package ppu_conv_pkg;

  localparam int STRIP_PIXELS = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_REQ  = 3'd1,
    S_READ_WAIT = 3'd2,
    S_SHIFT     = 3'd3,
    S_CONVERT   = 3'd4,
    S_WRITE     = 3'd5,
    S_DONE      = 3'd6
  } convState_t;

  typedef enum logic [1:0] {
    BPP_2     = 2'd0,
    BPP_4     = 2'd1,
    BPP_8     = 2'd2,
    BPP_8_ALT = 2'd3
  } bppMode_t;

  // log2 of the bytes occupied by one tile: 16/32/64 bytes
  function automatic logic [2:0] bpp_shift(input bppMode_t mode);
    case (mode)
      BPP_2:   return 3'd4;
      BPP_4:   return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic [3:0] bpp_planes(input bppMode_t mode);
    case (mode)
      BPP_2:   return 4'd2;
      BPP_4:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] bpp_mask(input bppMode_t mode);
    case (mode)
      BPP_2:   return 8'h03;
      BPP_4:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ppu_plane_transpose.sv
// Combinational 8x8 bit transpose: pixel i of the strip becomes bit (7-i) of every plane byte.
module ppu_plane_transpose (
  input  logic [7:0][7:0] pixels,
  output logic [7:0][7:0] planes
);

  for (genvar p = 0; p < 8; p++) begin : gPlane
    for (genvar i = 0; i < 8; i++) begin : gPixel
      assign planes[p][7-i] = pixels[i][p];
    end
  end

endmodule

// File: rtl/ppu_tile_converter.sv
// Linear 16-bit framebuffer to SNES bitplane tile converter (2/4/8 bpp, runtime selected).
// Optional diagnostics counters on the debug port are enabled by defining SRT_PPU_CONV_DEBUG_EN.
module ppu_tile_converter
  import ppu_conv_pkg::*;
#(
  parameter int TILES_X        = 25,
  parameter int TILES_Y        = 20,
  parameter int ADDR_W         = 15,
  parameter int SRC_LATENCY    = 1,
  parameter int PALETTE_BYPASS = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_tick,
  input  logic [1:0]        bpp_mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              active,
  output logic              done_tick,
  output logic [ADDR_W-1:0] in_read_addr,
  output logic              in_read_req,
  input  logic              in_read_ok,
  input  logic [15:0]       in_read_data,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic              out_write_en,
  input  logic              out_write_ready,
  output logic [7:0]        out_write_data,
  output logic [63:0]       debug
);

  localparam int WAIT_CYC = SRC_LATENCY + ((PALETTE_BYPASS != 0) ? 0 : 1);

  convState_t        state, nextState;
  bppMode_t          bppSel;
  logic [ADDR_W-1:0] srcBaseReg, dstBaseReg, pixCount, wrAddr;
  logic [2:0]        pixInStrip, lineY, plane;
  logic [15:0]       tileIdx, rowStart, tileX, tileY;
  logic [7:0]        waitCnt, idxReg, paletteIdx;
  logic [7:0][7:0]   strip, planesReg, transposed;
  logic              waitDone, lastPlane, lastStrip;

  // Palette lookup: bypass takes the low byte, otherwise a registered RGB555 -> luma index ROM
  if (PALETTE_BYPASS != 0) begin : gBypass
    assign paletteIdx = in_read_data[7:0];
  end else begin : gRom
    logic [7:0] romIdx;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        romIdx <= '0;
      end else begin
        romIdx <= in_read_data[15] ? 8'h00 :
                  8'((13'(in_read_data[14:10]) * 13'd77 +
                      13'(in_read_data[9:5])   * 13'd150 +
                      13'(in_read_data[4:0])   * 13'd29) >> 5);
      end
    end
    assign paletteIdx = romIdx;
  end

  ppu_plane_transpose uTranspose (
    .pixels (strip),
    .planes (transposed)
  );

  assign waitDone  = (waitCnt == 8'(WAIT_CYC - 1));
  assign lastPlane = (plane == 3'(bpp_planes(bppSel) - 4'd1));
  assign lastStrip = (tileX == 16'(TILES_X - 1)) && (lineY == 3'd7) &&
                     (tileY == 16'(TILES_Y - 1));
  assign wrAddr    = dstBaseReg
                   + ADDR_W'({16'd0, tileIdx} << bpp_shift(bppSel))
                   + ADDR_W'({plane[2:1], 4'b0000})
                   + ADDR_W'({lineY, 1'b0})
                   + ADDR_W'(plane[0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bppSel     <= BPP_2;
      srcBaseReg <= '0;
      dstBaseReg <= '0;
      pixCount   <= '0;
      pixInStrip <= '0;
      lineY      <= '0;
      plane      <= '0;
      tileIdx    <= '0;
      rowStart   <= '0;
      tileX      <= '0;
      tileY      <= '0;
      waitCnt    <= '0;
      idxReg     <= '0;
      strip      <= '0;
      planesReg  <= '0;
    end else begin
      state <= nextState;
      case (state)
        S_IDLE: begin
          if (start_tick) begin
            bppSel     <= (bpp_mode == 2'd3) ? BPP_8 : bppMode_t'(bpp_mode);
            srcBaseReg <= src_base;
            dstBaseReg <= dst_base;
            pixCount   <= '0;
            pixInStrip <= '0;
            lineY      <= '0;
            plane      <= '0;
            tileIdx    <= '0;
            rowStart   <= '0;
            tileX      <= '0;
            tileY      <= '0;
          end
        end
        S_READ_REQ: begin
          if (in_read_ok) begin
            waitCnt  <= '0;
            pixCount <= pixCount + 1'b1;
          end
        end
        S_READ_WAIT: begin
          waitCnt <= waitCnt + 8'd1;
          if (waitDone) idxReg <= paletteIdx & bpp_mask(bppSel);
        end
        S_SHIFT: begin
          // Newest pixel enters at the top so the first-read pixel ends in slot 0
          strip      <= {idxReg, strip[7:1]};
          pixInStrip <= pixInStrip + 3'd1;
        end
        S_CONVERT: begin
          planesReg <= transposed;
          plane     <= '0;
        end
        S_WRITE: begin
          if (out_write_ready) begin
            if (!lastPlane) begin
              plane <= plane + 3'd1;
            end else begin
              plane <= '0;
              if (tileX != 16'(TILES_X - 1)) begin
                tileX   <= tileX + 16'd1;
                tileIdx <= tileIdx + 16'd1;
              end else if (lineY != 3'd7) begin
                tileX   <= '0;
                lineY   <= lineY + 3'd1;
                tileIdx <= rowStart;
              end else begin
                tileX    <= '0;
                lineY    <= '0;
                tileY    <= tileY + 16'd1;
                rowStart <= rowStart + 16'(TILES_X);
                tileIdx  <= rowStart + 16'(TILES_X);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState      = state;
    active         = (state != S_IDLE);
    done_tick      = (state == S_DONE);
    in_read_req    = 1'b0;
    in_read_addr   = '0;
    out_write_en   = 1'b0;
    out_write_addr = '0;
    out_write_data = '0;
    case (state)
      S_IDLE:      if (start_tick) nextState = S_READ_REQ;
      S_READ_REQ: begin
        in_read_req  = 1'b1;
        in_read_addr = srcBaseReg + pixCount;
        if (in_read_ok) nextState = S_READ_WAIT;
      end
      S_READ_WAIT: if (waitDone) nextState = S_SHIFT;
      S_SHIFT:     nextState = (pixInStrip == 3'(STRIP_PIXELS - 1)) ? S_CONVERT : S_READ_REQ;
      S_CONVERT:   nextState = S_WRITE;
      S_WRITE: begin
        out_write_en   = 1'b1;
        out_write_addr = wrAddr;
        out_write_data = planesReg[plane];
        if (out_write_ready && lastPlane) nextState = lastStrip ? S_DONE : S_READ_REQ;
      end
      S_DONE:      nextState = S_IDLE;
      default:     nextState = S_IDLE;
    endcase
  end

`ifdef SRT_PPU_CONV_DEBUG_EN
  logic [15:0] framesDone, readCount, stallCount;

  // Read and stall counts restart with each frame; frames_done persists until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      framesDone <= '0;
      readCount  <= '0;
      stallCount <= '0;
    end else begin
      if (state == S_DONE) framesDone <= framesDone + 16'd1;
      if (state == S_IDLE && start_tick) begin
        readCount  <= '0;
        stallCount <= '0;
      end else begin
        if (state == S_READ_REQ && in_read_ok) readCount <= readCount + 16'd1;
        if (state == S_WRITE && !out_write_ready && stallCount != 16'hFFFF)
          stallCount <= stallCount + 16'd1;
      end
    end
  end

  assign debug = {8'(state), (state == S_IDLE) ? 8'd0 : 8'(bpp_planes(bppSel)),
                  framesDone, readCount, stallCount};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_ppu_tile_converter.sv
// Directed self-checking bench for ppu_tile_converter (2x1 tiles, palette bypass, latency 1).
module tb_ppu_tile_converter;

  localparam int TX = 2;
  localparam int TY = 1;
  localparam int AW = 15;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_tick = 1'b0;
  logic [1:0]    bpp_mode = 2'd0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          active, done_tick, in_read_req, out_write_en;
  logic [AW-1:0] in_read_addr, out_write_addr;
  logic          in_read_ok = 1'b1;
  logic [15:0]   in_read_data = '0;
  logic          out_write_ready = 1'b1;
  logic [7:0]    out_write_data;
  logic [63:0]   debug;

  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  logic [AW-1:0] wrAddrQ[$];
  logic [7:0]    wrDataQ[$];
  logic [15:0]   srcMem [0:255];
  logic [1:0]    tbMode = 2'd0;
  logic [AW-1:0] tbSrcBase = '0;
  logic [AW-1:0] tbDstBase = '0;

  ppu_tile_converter #(
    .TILES_X(TX), .TILES_Y(TY), .ADDR_W(AW), .SRC_LATENCY(1), .PALETTE_BYPASS(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_tick(start_tick), .bpp_mode(bpp_mode),
    .src_base(src_base), .dst_base(dst_base), .active(active), .done_tick(done_tick),
    .in_read_addr(in_read_addr), .in_read_req(in_read_req), .in_read_ok(in_read_ok),
    .in_read_data(in_read_data), .out_write_addr(out_write_addr), .out_write_en(out_write_en),
    .out_write_ready(out_write_ready), .out_write_data(out_write_data), .debug(debug)
  );

  always #5 clock = ~clock;

  // Source RAM with one cycle of read latency
  always @(posedge clock)
    if (in_read_req && in_read_ok) in_read_data <= srcMem[8'(in_read_addr - tbSrcBase)];

  // Record every accepted write and every done pulse
  always begin
    @(negedge clock);
    #1;
    if (out_write_en && out_write_ready) begin
      wrAddrQ.push_back(out_write_addr);
      wrDataQ.push_back(out_write_data);
    end
    if (done_tick) doneCnt++;
  end

  function automatic void expectedWrite(input int k, output logic [AW-1:0] a, output logic [7:0] d);
    int planes, shift, s, p, ty, y, tx, tile;
    logic [7:0] mask, pix;
    planes = (tbMode == 2'd0) ? 2 : (tbMode == 2'd1) ? 4 : 8;
    shift  = (tbMode == 2'd0) ? 4 : (tbMode == 2'd1) ? 5 : 6;
    mask   = (tbMode == 2'd0) ? 8'h03 : (tbMode == 2'd1) ? 8'h0F : 8'hFF;
    s = k / planes;
    p = k % planes;
    ty = s / (8 * TX);
    y = (s / TX) % 8;
    tx = s % TX;
    tile = ty * TX + tx;
    a = AW'(int'(tbDstBase) + (tile << shift) + (p / 2) * 16 + y * 2 + (p % 2));
    d = '0;
    for (int i = 0; i < 8; i++) begin
      pix = 8'(srcMem[(ty * 8 + y) * TX * 8 + tx * 8 + i]) & mask;
      d[7-i] = pix[p];
    end
  endfunction

  function automatic int frameErrors();
    logic [AW-1:0] ea;
    logic [7:0] ed;
    int e = 0;
    for (int k = 0; k < wrAddrQ.size(); k++) begin
      expectedWrite(k, ea, ed);
      if (wrAddrQ[k] !== ea || wrDataQ[k] !== ed) e++;
    end
    return e;
  endfunction

  task automatic fillPowers();
    for (int i = 0; i < 256; i++) srcMem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) srcMem[i] = 16'(1 << i);
  endtask

  task automatic startFrame(input logic [1:0] mode, input logic [AW-1:0] sb, input logic [AW-1:0] db);
    wrAddrQ.delete();
    wrDataQ.delete();
    doneCnt = 0;
    tbMode = mode;
    tbSrcBase = sb;
    tbDstBase = db;
    @(negedge clock);
    bpp_mode = mode;
    src_base = sb;
    dst_base = db;
    start_tick = 1'b1;
    @(negedge clock);
    start_tick = 1'b0;
  endtask

  task automatic waitFrame(output bit finished);
    finished = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      #2;
      if (!active) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #2;
    total++;
    if ({active, done_tick, in_read_req, out_write_en, in_read_addr, out_write_addr, out_write_data} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: active=%b req=%b en=%b raddr=%h waddr=%h wdata=%h, want all 0",
               active, in_read_req, out_write_en, in_read_addr, out_write_addr, out_write_data);
    end
    total++;
    if (debug !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_debug: got %h want 0", debug);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_8bpp();
    int spotK[4] = '{0, 1, 7, 8};
    logic [AW-1:0] spotA[4] = '{15'h000, 15'h001, 15'h031, 15'h040};
    logic [7:0] spotD[4] = '{8'h80, 8'h40, 8'h01, 8'h00};
    bit fin;
    int errs;
    fillPowers();
    startFrame(2'd2, '0, '0);
    repeat (100) @(negedge clock);
    bpp_mode = 2'd0;
    dst_base = 15'h200;
    start_tick = 1'b1;
    @(negedge clock);
    start_tick = 1'b0;
    waitFrame(fin);
    total++;
    if (!fin) begin bad++; $display("[TB] FAIL 8bpp_timeout: frame still active after budget"); end
    total++;
    if (wrAddrQ.size() != 128) begin bad++; $display("[TB] FAIL 8bpp_count: got %0d want 128", wrAddrQ.size()); end
    total++;
    if (doneCnt != 1) begin bad++; $display("[TB] FAIL 8bpp_done: got %0d want 1", doneCnt); end
    for (int j = 0; j < 4; j++) begin
      if (wrAddrQ.size() > spotK[j]) begin
        total++;
        if (wrAddrQ[spotK[j]] !== spotA[j] || wrDataQ[spotK[j]] !== spotD[j]) begin
          bad++;
          $display("[TB] FAIL 8bpp_byte%0d: got addr=%h data=%h want addr=%h data=%h", spotK[j],
                   wrAddrQ[spotK[j]], wrDataQ[spotK[j]], spotA[j], spotD[j]);
        end
      end
    end
    errs = frameErrors();
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL 8bpp_model: %0d bytes differ, want 0", errs); end
  endtask

  task automatic test_2bpp_dst();
    bit fin;
    bit [31:0] seen;
    int dups, nonFF, errs;
    for (int i = 0; i < 256; i++) srcMem[i] = 16'h0003;
    startFrame(2'd0, '0, 15'h100);
    fin = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      start_tick = 1'b0;
      #2;
      if (done_tick) start_tick = 1'b1;
      if (!active) begin fin = 1'b1; break; end
    end
    start_tick = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    total++;
    if (!fin || active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL 2bpp_done_start: finished=%b active=%b want finished=1 active=0", fin, active);
    end
    total++;
    if (wrAddrQ.size() != 32) begin bad++; $display("[TB] FAIL 2bpp_count: got %0d want 32", wrAddrQ.size()); end
    seen = '0;
    dups = 0;
    nonFF = 0;
    for (int k = 0; k < wrAddrQ.size(); k++) begin
      if (wrAddrQ[k] >= 15'h100 && wrAddrQ[k] <= 15'h11F && !seen[5'(wrAddrQ[k] - 15'h100)])
        seen[5'(wrAddrQ[k] - 15'h100)] = 1'b1;
      else dups++;
      if (wrDataQ[k] !== 8'hFF) nonFF++;
    end
    total++;
    if (seen !== 32'hFFFF_FFFF || dups != 0) begin
      bad++;
      $display("[TB] FAIL 2bpp_cover: seen=%h stray=%0d want ffffffff and 0", seen, dups);
    end
    total++;
    if (nonFF != 0) begin bad++; $display("[TB] FAIL 2bpp_data: %0d bytes not FF, want 0", nonFF); end
    if (wrAddrQ.size() > 2) begin
      total++;
      if (wrAddrQ[2] !== 15'h110) begin bad++; $display("[TB] FAIL 2bpp_tile1: got %h want 0110", wrAddrQ[2]); end
    end
    errs = frameErrors();
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL 2bpp_model: %0d bytes differ, want 0", errs); end
  endtask

  task automatic test_4bpp_mask();
    bit fin;
    int nonFF, errs;
    for (int i = 0; i < 256; i++) srcMem[i] = 16'h001F;
    startFrame(2'd1, '0, '0);
    waitFrame(fin);
    total++;
    if (!fin || wrAddrQ.size() != 64) begin
      bad++;
      $display("[TB] FAIL 4bpp_count: finished=%b got %0d want 64", fin, wrAddrQ.size());
    end
    nonFF = 0;
    foreach (wrDataQ[k]) if (wrDataQ[k] !== 8'hFF) nonFF++;
    total++;
    if (nonFF != 0) begin bad++; $display("[TB] FAIL 4bpp_data: %0d bytes not FF, want 0", nonFF); end
    if (wrAddrQ.size() > 3) begin
      total++;
      if (wrAddrQ[2] !== 15'h010 || wrAddrQ[3] !== 15'h011) begin
        bad++;
        $display("[TB] FAIL 4bpp_plane2: got %h/%h want 0010/0011", wrAddrQ[2], wrAddrQ[3]);
      end
    end
    errs = frameErrors();
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL 4bpp_model: %0d bytes differ, want 0", errs); end
  endtask

  task automatic test_write_stall();
    bit fin, got3;
    logic [AW-1:0] heldAddr;
    logic [7:0] heldData;
    int errs;
    fillPowers();
    startFrame(2'd2, '0, '0);
    got3 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      #2;
      if (wrAddrQ.size() >= 3) begin got3 = 1'b1; break; end
    end
    total++;
    if (!got3) begin bad++; $display("[TB] FAIL wstall_reach: only %0d writes, want 3", wrAddrQ.size()); end
    @(negedge clock);
    out_write_ready = 1'b0;
    #2;
    heldAddr = out_write_addr;
    heldData = out_write_data;
    total++;
    if (out_write_en !== 1'b1 || heldAddr !== 15'h011 || heldData !== 8'h10) begin
      bad++;
      $display("[TB] FAIL wstall_present: en=%b addr=%h data=%h want 1/0011/10", out_write_en, heldAddr, heldData);
    end
    repeat (4) begin
      @(negedge clock);
      #2;
      total++;
      if (out_write_en !== 1'b1 || out_write_addr !== heldAddr || out_write_data !== heldData) begin
        bad++;
        $display("[TB] FAIL wstall_hold: en=%b addr=%h data=%h want 1/%h/%h",
                 out_write_en, out_write_addr, out_write_data, heldAddr, heldData);
      end
    end
    @(negedge clock);
    out_write_ready = 1'b1;
    waitFrame(fin);
    errs = frameErrors();
    total++;
    if (!fin || wrAddrQ.size() != 128 || errs != 0) begin
      bad++;
      $display("[TB] FAIL wstall_frame: finished=%b count=%0d diffs=%0d want 1/128/0", fin, wrAddrQ.size(), errs);
    end
`ifdef SRT_PPU_CONV_DEBUG_EN
    total++;
    if (debug[15:0] !== 16'd5 || debug[31:16] !== 16'd128) begin
      bad++;
      $display("[TB] FAIL wstall_debug: stalls=%0d reads=%0d want 5/128", debug[15:0], debug[31:16]);
    end
`else
    total++;
    if (debug !== 64'd0) begin bad++; $display("[TB] FAIL debug_off: got %h want 0", debug); end
`endif
  endtask

  task automatic test_read_stall();
    bit fin;
    int errs;
    fillPowers();
    in_read_ok = 1'b0;
    startFrame(2'd2, 15'h040, '0);
    repeat (3) begin
      #2;
      total++;
      if (in_read_req !== 1'b1 || in_read_addr !== 15'h040) begin
        bad++;
        $display("[TB] FAIL rstall_hold: req=%b addr=%h want 1/0040", in_read_req, in_read_addr);
      end
      @(negedge clock);
    end
    in_read_ok = 1'b1;
    waitFrame(fin);
    errs = frameErrors();
    total++;
    if (!fin || wrAddrQ.size() != 128 || errs != 0 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL rstall_frame: finished=%b count=%0d diffs=%0d done=%0d want 1/128/0/1",
               fin, wrAddrQ.size(), errs, doneCnt);
    end
    if (wrDataQ.size() > 0) begin
      total++;
      if (wrDataQ[0] !== 8'h80) begin bad++; $display("[TB] FAIL rstall_first: got %h want 80", wrDataQ[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit fin;
    int errs;
    fillPowers();
    startFrame(2'd2, '0, '0);
    repeat (60) @(negedge clock);
    reset_n = 1'b0;
    #2;
    total++;
    if ({active, done_tick, in_read_req, out_write_en, in_read_addr, out_write_addr, out_write_data} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: active=%b req=%b en=%b raddr=%h waddr=%h wdata=%h, want all 0",
               active, in_read_req, out_write_en, in_read_addr, out_write_addr, out_write_data);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    #2;
    total++;
    if (doneCnt != 0 || active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_nodone: done=%0d active=%b want 0/0", doneCnt, active);
    end
    startFrame(2'd2, '0, 15'h020);
    waitFrame(fin);
    errs = frameErrors();
    total++;
    if (!fin || wrAddrQ.size() != 128 || errs != 0 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL midreset_fresh: finished=%b count=%0d diffs=%0d done=%0d want 1/128/0/1",
               fin, wrAddrQ.size(), errs, doneCnt);
    end
  endtask

  initial begin
    test_reset();
    test_8bpp();
    test_2bpp_dst();
    test_4bpp_mask();
    test_write_stall();
    test_read_stall();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_tile_converter.md
Name: ppu_tile_converter

Overview:
- Parametrised successor to the fixed 8bpp PPU image converter.
- Reads a linear framebuffer of 16-bit colour words and maps each to a palette index.
- Transposes 8-pixel strips into SNES bitplane tile format at a runtime-selected depth (2, 4 or 8 bpp), then writes bytes to the SNES framebuffer RAM.
- Adds write back-pressure, relocatable source/destination bases and a variable-latency read handshake.

Parameters:
- TILES_X, 25, tiles per row
- TILES_Y, 20, tile rows
- ADDR_W, 15, address width of both RAM ports
- SRC_LATENCY, 1, cycles from an accepted read to valid in_read_data (min 1)
- PALETTE_BYPASS, 0, 1 = palette index is in_read_data[7:0] (no ROM)

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- start_tick  in  1  begin conversion (ignored unless idle)
- bpp_mode  in  2  0=2bpp, 1=4bpp, 2=8bpp, 3=8bpp; latched on start
- src_base  in  ADDR_W  source word address of pixel (0,0); latched on start
- dst_base  in  ADDR_W  destination byte address of tile 0; latched on start
- active  out  1  high while not idle
- done_tick  out  1  one-cycle pulse at completion
- in_read_addr  out  ADDR_W  source word address
- in_read_req  out  1  read request
- in_read_ok  in  1  grant; read accepted when req&ok
- in_read_data  in  16  source colour word
- out_write_addr  out  ADDR_W  destination byte address
- out_write_en  out  1  write strobe
- out_write_ready  in  1  sink accepts write when en&ready
- out_write_data  out  8  bitplane byte
- debug  out  64  diagnostics

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-run abandons the frame and produces no done_tick.
- FSM states: IDLE -> READ_REQ -> READ_WAIT -> SHIFT -> (READ_REQ until 8 pixels, else CONVERT) -> WRITE -> (next strip READ_REQ | DONE) -> IDLE.
- IDLE:
  - active=0.
  - On start_tick: latch bpp_mode/src_base/dst_base, clear counters, go to READ_REQ.
  - start_tick in any other state is ignored.
- READ_REQ:
  - in_read_req=1 and in_read_addr = src_base + linear pixel count (mod 2^ADDR_W).
  - Hold until in_read_ok; exactly one outstanding read at a time.
- READ_WAIT:
  - Wait SRC_LATENCY cycles, plus 1 for the palette ROM when PALETTE_BYPASS=0.
  - Capture the index and mask it to bpp bits.
- SHIFT: shift the index into the 8-entry strip (first-read pixel ends up leftmost, plane bit 7).
- CONVERT: transpose the strip; plane p byte bit (7-i) = pixel i bit p.
- WRITE:
  - Emit bpp bytes, plane 0 first; out_write_en stays high until accepted.
  - Data and address are held stable while ready=0.
  - Advance to the next plane only on acceptance.
- Address of the plane-p byte:
  - dst_base + (tile << (log2(bpp)+3)) + (p>>1)*16 + y*2 + (p&1), mod 2^ADDR_W.
  - tile = ty*TILES_X + tx; the shift term is 4/5/6 for 2/4/8bpp.
- Traversal order: ty, then y 0..7, then tx. At end of a line, tile returns to the row start; after y=7 it advances to the next row.
- Completion:
  - The last byte of tile TILES_X*TILES_Y-1, y=7, is accepted; done_tick pulses the next cycle in DONE, then the FSM returns to IDLE.
  - A start_tick in the same cycle as the done_tick pulse is ignored.
- Total bytes written = TILES_X*TILES_Y*8*bpp.

Optional Feature:
- Macro: SRT_PPU_CONV_DEBUG_EN.
- Defined: debug = {state[7:0], 8'(bpp), frames_done[15:0], read_count[15:0], write_stall_cycles[15:0]}.
  - frames_done increments on done_tick.
  - write_stall_cycles counts en&!ready cycles per frame and saturates at 0xFFFF.
  - All counters are cleared by reset.
- Undefined: debug tied to 0 and no counters are synthesised.

Decomposition:
- Package ppu_conv_pkg:
  - state enum;
  - bpp_mode encodings;
  - function bpp_shift(mode) returning 4/5/6;
  - constant STRIP_PIXELS=8.
- Sub-module ppu_plane_transpose: combinational 8x8 bit transpose, reused by future converters.
- The palette ROM remains the existing instance, generated only when PALETTE_BYPASS=0.

Test Plan (bench: PALETTE_BYPASS=1, TILES_X=2, TILES_Y=1, SRC_LATENCY=1, ok/ready=1 unless stated):
- 8bpp, src row0 pixels 0x01,0x02,0x04..0x80, rest 0 -> addr 0 data 0x80, addr 1 data 0x40, …, plane7 at addr 0x31 data 0x01; 128 writes; one done_tick.
- 2bpp, dst_base=0x100, all pixels 0x03 -> 32 writes of 0xFF at 0x100..0x11F; tile1 starts 0x110.
- 4bpp, pixel value 0x1F (masked to 0xF) everywhere -> 64 writes, all 0xFF; plane2 of tile0 y=0 at addr 0x10.
- out_write_ready low 5 cycles mid-strip -> en/addr/data held; no byte lost or duplicated; stall counter=5 with the macro.
- in_read_ok withheld 3 cycles -> in_read_req and addr stable; output identical to the unstalled run.
- reset_n asserted mid-frame, then start_tick -> outputs 0 and no done_tick; fresh frame completes correctly.
